// File: rtl/tetris_pkg.sv
// Shared piece definitions for the piece stream path.
// PIECE_W        : width of a piece code
// NUM_PIECES_DEF : default number of distinct piece codes
// PIECE_*        : named piece codes
package tetris_pkg;
  localparam int PIECE_W        = 3;
  localparam int NUM_PIECES_DEF = 6;

  typedef logic [PIECE_W-1:0] piece_t;

  localparam piece_t PIECE_I = 3'd0;
  localparam piece_t PIECE_O = 3'd1;
  localparam piece_t PIECE_T = 3'd2;
  localparam piece_t PIECE_S = 3'd3;
  localparam piece_t PIECE_Z = 3'd4;
  localparam piece_t PIECE_L = 3'd5;
endpackage

// File: rtl/bag_tracker.sv
// Bag randomizer: each piece code is handed out once per bag. Owns the bag
// mask and the consecutive-reject counter.
// clk, rst   : clock, async active-low reset
// rnd_in     : raw RNG sample
// fill_en    : queue can take a piece this cycle (already excludes flush)
// flush      : synchronous clear of bag state
// accept     : push_code should be pushed this cycle
// push_code  : code to push (the sample, or the lowest free code on fallback)
module bag_tracker
  import tetris_pkg::*;
#(
  parameter int NUM_PIECES   = NUM_PIECES_DEF,
  parameter int REJECT_LIMIT = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  piece_t rnd_in,
  input  logic   fill_en,
  input  logic   flush,
  output logic   accept,
  output piece_t push_code
);
  localparam int RC_W = $clog2(REJECT_LIMIT + 1);

  logic [NUM_PIECES-1:0] bag_mask_q, bag_mask_d, mask_set;
  logic [RC_W-1:0]       reject_cnt_q, reject_cnt_d;
  logic                  is_free, fallback;
  piece_t                low_free;

  always_comb begin
    is_free  = 1'b0;
    low_free = '0;
    // Descending scan so the last write is the lowest free index.
    for (int i = NUM_PIECES - 1; i >= 0; i--)
      if (!bag_mask_q[i]) low_free = piece_t'(i);
    // Out-of-range samples never match any index, so they reject.
    for (int i = 0; i < NUM_PIECES; i++)
      if (rnd_in == piece_t'(i) && !bag_mask_q[i]) is_free = 1'b1;
    fallback  = !is_free && (reject_cnt_q == RC_W'(REJECT_LIMIT - 1));
    accept    = fill_en && (is_free || fallback);
    push_code = is_free ? rnd_in : low_free;
    mask_set  = bag_mask_q | (NUM_PIECES'(1) << push_code);

    bag_mask_d   = bag_mask_q;
    reject_cnt_d = reject_cnt_q;
    if (flush) begin
      bag_mask_d   = '0;
      reject_cnt_d = '0;
    end else if (accept) begin
      // Completing the bag starts a fresh one in the same cycle.
      bag_mask_d   = (&mask_set) ? '0 : mask_set;
      reject_cnt_d = '0;
    end else if (fill_en && reject_cnt_q != RC_W'(REJECT_LIMIT)) begin
      reject_cnt_d = reject_cnt_q + RC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bag_mask_q   <= '0;
      reject_cnt_q <= '0;
    end else begin
      bag_mask_q   <= bag_mask_d;
      reject_cnt_q <= reject_cnt_d;
    end
  end
endmodule

// File: rtl/piece_queue.sv
// Preview queue of upcoming pieces fed from the RNG through a bag randomizer.
// clk, rst    : clock, async active-low reset
// rnd_in      : RNG sample, may change every cycle
// flush       : synchronous clear for a new game (beats take)
// piece_take  : consumer pops the head this cycle
// piece_valid : head entry valid
// piece_out   : head piece code
// preview     : all entries, entry i at [3i+2:3i], empty slots read 0
// count       : valid entries, 0..DEPTH
module piece_queue
  import tetris_pkg::*;
#(
  parameter int NUM_PIECES   = NUM_PIECES_DEF,
  parameter int DEPTH        = 4,
  parameter int REJECT_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PIECE_W-1:0]         rnd_in,
  input  logic                       flush,
  input  logic                       piece_take,
  output logic                       piece_valid,
  output logic [PIECE_W-1:0]         piece_out,
  output logic [PIECE_W*DEPTH-1:0]   preview,
  output logic [3:0]                 count
);
  logic [DEPTH-1:0][PIECE_W-1:0] entry_q, entry_d;
  logic [3:0]                    count_q, count_d, wr_idx;
  logic                          valid_q, valid_d;
  logic                          fill_en, pop, accept;
  piece_t                        push_code;

  // Eligibility uses the pre-pop count: a full queue popped this cycle
  // refills on the next one.
  assign fill_en = (count_q < 4'(DEPTH)) && !flush;
  assign pop     = piece_take && valid_q && !flush;

  bag_tracker #(
    .NUM_PIECES   (NUM_PIECES),
    .REJECT_LIMIT (REJECT_LIMIT)
  ) u_bag (
    .clk       (clk),
    .rst       (rst),
    .rnd_in    (rnd_in),
    .fill_en   (fill_en),
    .flush     (flush),
    .accept    (accept),
    .push_code (push_code)
  );

  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    wr_idx  = count_q;
    if (flush) begin
      entry_d = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        // Shift toward the head; zero fills the vacated tail slot.
        for (int i = 0; i < DEPTH - 1; i++) entry_d[i] = entry_q[i+1];
        entry_d[DEPTH-1] = '0;
        wr_idx  = count_q - 4'd1;
        count_d = count_q - 4'd1;
      end
      if (accept) begin
        for (int i = 0; i < DEPTH; i++)
          if (wr_idx == 4'(i)) entry_d[i] = push_code;
        count_d = wr_idx + 4'd1;
      end
    end
    valid_d = (count_d != 4'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign piece_valid = valid_q;
  assign piece_out   = entry_q[0];
  assign preview     = entry_q;
  assign count       = count_q;
endmodule

// File: tb/tb_piece_queue.sv
// Directed + short random bench for piece_queue with a reference queue model.
module tb_piece_queue;
  localparam int NP = 6, DEPTH = 4, LIM = 8;

  logic                 clk = 1'b0, rst = 1'b0, flush = 1'b0, piece_take = 1'b0;
  logic [2:0]           rnd_in = '0;
  logic                 piece_valid;
  logic [2:0]           piece_out;
  logic [3*DEPTH-1:0]   preview;
  logic [3:0]           count;

  int          n_tests = 0, n_fail = 0;
  int          mq[$];
  logic [NP-1:0] mmask = '0;
  int          mrej = 0;

  always #5 clk = ~clk;

  piece_queue #(.NUM_PIECES(NP), .DEPTH(DEPTH), .REJECT_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .rnd_in(rnd_in), .flush(flush), .piece_take(piece_take),
    .piece_valid(piece_valid), .piece_out(piece_out), .preview(preview), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge.
  task automatic model_clk(input logic [2:0] r, input logic tk, input logic fl);
    bit fill, pop;
    int code;
    fill = (mq.size() < DEPTH) && !fl;
    pop  = tk && (mq.size() != 0) && !fl;
    if (fl) begin
      mq.delete(); mmask = '0; mrej = 0;
      return;
    end
    if (pop) void'(mq.pop_front());
    if (fill) begin
      code = -1;
      if (int'(r) < NP && !mmask[r]) code = int'(r);
      else if (mrej == LIM - 1)
        for (int i = NP - 1; i >= 0; i--) if (!mmask[i]) code = i;
      if (code >= 0) begin
        mq.push_back(code);
        mmask[code] = 1'b1;
        if (&mmask) mmask = '0;
        mrej = 0;
      end else if (mrej < LIM) mrej++;
    end
  endtask

  task automatic check_model(input string tag);
    logic [3*DEPTH-1:0] exp_prev;
    exp_prev = '0;
    for (int i = 0; i < DEPTH; i++)
      if (i < mq.size()) exp_prev[3*i +: 3] = 3'(mq[i]);
    chk({tag, "_count"}, 32'(count), 32'(mq.size()));
    chk({tag, "_valid"}, 32'(piece_valid), 32'(mq.size() != 0));
    chk({tag, "_head"},  32'(piece_out), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk({tag, "_prev"},  32'(preview), 32'(exp_prev));
    chk({tag, "_rej"},   32'(dut.u_bag.reject_cnt_q), 32'(mrej));
    chk({tag, "_mask"},  32'(dut.u_bag.bag_mask_q), 32'(mmask));
  endtask

  task automatic step(input string tag, input logic [2:0] r, input logic tk, input logic fl);
    rnd_in = r; piece_take = tk; flush = fl;
    @(posedge clk);
    model_clk(r, tk, fl);
    #1;
    check_model(tag);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(piece_valid), 0);
    chk("rst_prev",  32'(preview), 0);
    chk("rst_head",  32'(piece_out), 0);
    rst = 1'b1;

    // 1: fill with 1,2,3,4
    for (int i = 1; i <= 4; i++) step("t1", 3'(i), 1'b0, 1'b0);
    chk("t1_count4", 32'(count), 4);
    chk("t1_prev",   32'(preview), 32'h8D1);
    chk("t1_head",   32'(piece_out), 1);

    // 2: rejects (out of range and already in bag)
    step("t2_pop", 3'd6, 1'b1, 1'b0);
    step("t2", 3'd6, 1'b0, 1'b0);
    step("t2", 3'd7, 1'b0, 1'b0);
    step("t2", 3'd1, 1'b0, 1'b0);
    chk("t2_rej3",   32'(dut.u_bag.reject_cnt_q), 3);
    chk("t2_count3", 32'(count), 3);

    // 3: full bag 0..5 with take each cycle, then new bag
    step("t3_fl", 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step("t3", 3'(i), 1'b1, 1'b0);
    chk("t3_mask0", 32'(dut.u_bag.bag_mask_q), 0);
    step("t3_nb", 3'd0, 1'b1, 1'b0);
    chk("t3_head0",  32'(piece_out), 0);
    chk("t3_count1", 32'(count), 1);

    // 4: fallback after REJECT_LIMIT rejects picks lowest free code
    step("t4_fl", 3'd0, 1'b0, 1'b1);
    step("t4", 3'd0, 1'b0, 1'b0);
    step("t4", 3'd2, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) step("t4r", 3'd2, 1'b0, 1'b0);
    chk("t4_rej7", 32'(dut.u_bag.reject_cnt_q), 7);
    step("t4f", 3'd2, 1'b0, 1'b0);
    chk("t4_count3", 32'(count), 3);
    chk("t4_prev",   32'(preview), 32'h050);
    chk("t4_rej0",   32'(dut.u_bag.reject_cnt_q), 0);

    // 5: push+pop keeps count; full + take pops only
    step("t5", 3'd7, 1'b1, 1'b0);
    step("t5pp", 3'd3, 1'b1, 1'b0);
    chk("t5_count2", 32'(count), 2);
    chk("t5_head1",  32'(piece_out), 1);
    step("t5", 3'd4, 1'b0, 1'b0);
    step("t5", 3'd5, 1'b0, 1'b0);
    step("t5full", 3'd0, 1'b1, 1'b0);
    chk("t5_count3", 32'(count), 3);
    chk("t5_head3",  32'(piece_out), 3);

    // 6: flush with take, then async reset mid-fill
    step("t6_fl", 3'd0, 1'b1, 1'b1);
    chk("t6_count0", 32'(count), 0);
    chk("t6_mask0",  32'(dut.u_bag.bag_mask_q), 0);
    step("t6", 3'd1, 1'b0, 1'b0);
    step("t6", 3'd2, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("t6_arst_count", 32'(count), 0);
    chk("t6_arst_valid", 32'(piece_valid), 0);
    chk("t6_arst_prev",  32'(preview), 0);
    chk("t6_arst_head",  32'(piece_out), 0);
    mq.delete(); mmask = '0; mrej = 0;
    @(negedge clk);
    rst = 1'b1;

    // Short random run against the model
    for (int k = 0; k < 60; k++)
      step("rnd", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
